histogram_derivative_stream: RTL and testbench

Streaming, parametrised discrete-derivative engine for intensity histograms. It accepts one histogram bin per cycle over a valid/ready handshake and emits one signed derivative per bin. It supports backward-difference or central-difference mode, saturation to a configurable output width, per-bin peak (positive-to-non-positive) flags, and a per-frame maximum-slope report. It sits between the histogram accumulator and the threshold-selection logic, replacing the flat 256×16 combinational difference.

---
 rtl/histogram_derivative_stream.sv | 229 ++++++++++++++++++++++
 tb/tb_histogram_derivative_stream.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_derivative_stream.sv
// -----------------------------------------------------------------------------
// histogram_derivative_stream
//
// Streaming discrete-derivative engine for intensity histograms. Bins arrive
// one per beat, in order 0..NUM_BINS-1, and one signed derivative leaves per
// bin. Two modes are supported:
//   backward : d[0] = 0, d[i] = h[i] - h[i-1]
//   central  : d[i] = (h[i+1] - h[i-1]) >>> 1, with the edges replicated
// Each result is saturated to OUT_WIDTH. A peak flag is raised when the
// previous derivative was positive and the current one is non-positive.
// The bin with the largest derivative of each completed frame is reported.
//
// Ports
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_mode           0 = backward, 1 = central (sampled on the bin 0 beat)
//   i_s_valid/o_s_ready/i_s_data          input bin stream
//   o_m_valid/i_m_ready/o_m_data          output derivative stream
//   o_m_bin, o_m_last, o_m_peak, o_m_sat  output sideband
//   o_frame_done     one-cycle pulse after the last output handshake
//   o_max_bin/o_max_val  largest derivative of the last completed frame
// -----------------------------------------------------------------------------
module histogram_derivative_stream #(
   parameter  int NUM_BINS  = 256,
   parameter  int IN_WIDTH  = 16,
   parameter  int OUT_WIDTH = 17,
   localparam int BW        = $clog2(NUM_BINS)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_mode,
   input  logic                 i_s_valid,
   output logic                 o_s_ready,
   input  logic [IN_WIDTH-1:0]  i_s_data,
   output logic                 o_m_valid,
   input  logic                 i_m_ready,
   output logic [OUT_WIDTH-1:0] o_m_data,
   output logic [BW-1:0]        o_m_bin,
   output logic                 o_m_last,
   output logic                 o_m_peak,
   output logic                 o_m_sat,
   output logic                 o_frame_done,
   output logic [BW-1:0]        o_max_bin,
   output logic [OUT_WIDTH-1:0] o_max_val
);

   localparam int            DW       = IN_WIDTH + 1;
   localparam logic [BW-1:0] LAST_BIN = BW'(NUM_BINS - 1);
   localparam longint        SAT_MAX  = (longint'(1) << (OUT_WIDTH - 1)) - 1;
   localparam longint        SAT_MIN  = -SAT_MAX - 1;

   typedef enum logic [1:0] {
      ST_FIRST = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t                       state;
   state_t                       state_nxt;
   logic [BW-1:0]                cnt;        // index of the next input bin
   logic                         mode_r;     // mode latched for the frame
   logic [IN_WIDTH-1:0]          h_prev1;    // h[i-1] relative to the incoming bin
   logic [IN_WIDTH-1:0]          h_prev2;    // h[i-2] relative to the incoming bin
   logic signed [OUT_WIDTH-1:0]  prev_d;     // last emitted derivative (peak detect)
   logic signed [OUT_WIDTH-1:0]  run_max_val;
   logic [BW-1:0]                run_max_bin;

   logic                         out_free;
   logic                         accept;
   logic                         load;
   logic                         mode_eff;
   logic                         out_hs;
   logic                         take_max;

   logic [IN_WIDTH-1:0]          sub_a;
   logic [IN_WIDTH-1:0]          sub_b;
   logic                         do_shift;
   logic signed [DW-1:0]         diff_raw;
   logic signed [DW-1:0]         diff;
   logic signed [OUT_WIDTH-1:0]  d_sat;
   logic                         clip;
   logic [BW-1:0]                bin_nxt;
   logic                         peak_nxt;

   assign out_free = !o_m_valid || i_m_ready;
   assign accept   = i_s_valid && o_s_ready;
   assign out_hs   = o_m_valid && i_m_ready;
   // In FIRST the live i_mode governs the bin 0 beat; afterwards the latched copy.
   assign mode_eff = (state == ST_FIRST) ? i_mode : mode_r;
   // Central mode emits nothing for bin 0; FLUSH produces the final bin on its own.
   assign load     = (accept && !(state == ST_FIRST && i_mode)) ||
                     (state == ST_FLUSH && out_free);

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= ST_FIRST;
      else          state <= state_nxt;
   end

   // NOTE: every variable written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_FIRST: if (accept) state_nxt = ST_RUN;
         ST_RUN:   if (accept && cnt == LAST_BIN)
                      state_nxt = mode_r ? ST_FLUSH : ST_FIRST;
         ST_FLUSH: if (out_free) state_nxt = ST_FIRST;
         default:  state_nxt = ST_FIRST;
      endcase
   end

   always_comb begin
      o_s_ready = i_rst_n && out_free && (state != ST_FLUSH);
   end

   // ---------------------------------------------------------------- datapath
   always_comb begin
      sub_a    = i_s_data;
      sub_b    = i_s_data;
      do_shift = 1'b0;
      if (state == ST_FLUSH) begin
         // h[N] replicates h[N-1]: d[N-1] = (h[N-1] - h[N-2]) >>> 1
         sub_a    = h_prev1;
         sub_b    = h_prev2;
         do_shift = 1'b1;
      end else if (mode_eff) begin
         // Incoming bin j yields d[j-1] = (h[j] - h[j-2]) >>> 1; h_prev2 holds
         // h[0] twice at the start, giving the h[-1] = h[0] replication.
         sub_b    = (state == ST_FIRST) ? i_s_data : h_prev2;
         do_shift = 1'b1;
      end else begin
         // Bin 0 subtracts itself so d[0] = 0.
         sub_b    = (state == ST_FIRST) ? i_s_data : h_prev1;
      end

      diff_raw = $signed({1'b0, sub_a}) - $signed({1'b0, sub_b});
      diff     = do_shift ? (diff_raw >>> 1) : diff_raw;

      clip  = 1'b0;
      d_sat = OUT_WIDTH'(diff);
      if (longint'(diff) > SAT_MAX) begin
         clip  = 1'b1;
         d_sat = OUT_WIDTH'(SAT_MAX);
      end else if (longint'(diff) < SAT_MIN) begin
         clip  = 1'b1;
         d_sat = OUT_WIDTH'(SAT_MIN);
      end

      if (state == ST_FLUSH) bin_nxt = LAST_BIN;
      else if (mode_eff)     bin_nxt = cnt - BW'(1);
      else                   bin_nxt = cnt;

      peak_nxt = (bin_nxt != '0) && (prev_d > 0) && (d_sat <= 0);
   end

   // Input side: bin counter, mode latch and history of the last two bins.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cnt     <= '0;
         mode_r  <= 1'b0;
         h_prev1 <= '0;
         h_prev2 <= '0;
      end else if (accept) begin
         if (state == ST_FIRST) begin
            mode_r  <= i_mode;
            cnt     <= BW'(1);
            h_prev1 <= i_s_data;
            h_prev2 <= i_s_data;
         end else begin
            cnt     <= (cnt == LAST_BIN) ? '0 : cnt + BW'(1);
            h_prev2 <= h_prev1;
            h_prev1 <= i_s_data;
         end
      end
   end

   // Single-entry output register; it holds while stalled.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_m_valid <= 1'b0;
         o_m_data  <= '0;
         o_m_bin   <= '0;
         o_m_last  <= 1'b0;
         o_m_peak  <= 1'b0;
         o_m_sat   <= 1'b0;
         prev_d    <= '0;
      end else if (load) begin
         o_m_valid <= 1'b1;
         o_m_data  <= d_sat;
         o_m_bin   <= bin_nxt;
         o_m_last  <= (bin_nxt == LAST_BIN);
         o_m_peak  <= peak_nxt;
         o_m_sat   <= clip;
         prev_d    <= d_sat;
      end else if (i_m_ready) begin
         o_m_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- frame max
   // Tracked on output handshakes; bin 0 seeds the tracker, strict '>' keeps
   // the lowest bin on ties.
   assign take_max = (o_m_bin == '0) || ($signed(o_m_data) > run_max_val);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         run_max_val  <= '0;
         run_max_bin  <= '0;
         o_max_bin    <= '0;
         o_max_val    <= '0;
         o_frame_done <= 1'b0;
      end else begin
         o_frame_done <= out_hs && o_m_last;
         if (out_hs) begin
            if (take_max) begin
               run_max_val <= $signed(o_m_data);
               run_max_bin <= o_m_bin;
            end
            if (o_m_last) begin
               o_max_bin <= take_max ? o_m_bin  : run_max_bin;
               o_max_val <= take_max ? o_m_data : run_max_val;
            end
         end
      end
   end

endmodule

// File: tb/tb_histogram_derivative_stream.sv
// -----------------------------------------------------------------------------
// Bench for histogram_derivative_stream. Two instances share one input stream:
// dut_a uses the full 17-bit output, dut_b an 8-bit output to exercise
// saturation. Expected derivatives come from hand-computed tables.
// -----------------------------------------------------------------------------
module tb_histogram_derivative_stream;

   localparam int NB  = 8;
   localparam int IW  = 16;
   localparam int OWA = 17;
   localparam int OWB = 8;
   localparam int BW  = 3;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          i_mode    = 1'b0;
   logic          i_s_valid = 1'b0;
   logic [IW-1:0] i_s_data  = '0;
   logic          i_m_ready = 1'b1;

   logic           s_ready_a, m_valid_a, m_last_a, m_peak_a, m_sat_a, fdone_a;
   logic [OWA-1:0] m_data_a, max_val_a;
   logic [BW-1:0]  m_bin_a, max_bin_a;
   logic           s_ready_b, m_valid_b, m_last_b, m_peak_b, m_sat_b, fdone_b;
   logic [OWB-1:0] m_data_b, max_val_b;
   logic [BW-1:0]  m_bin_b, max_bin_b;

   always #5 clk = ~clk;

   histogram_derivative_stream #(.NUM_BINS(NB), .IN_WIDTH(IW), .OUT_WIDTH(OWA)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(i_mode),
      .i_s_valid(i_s_valid), .o_s_ready(s_ready_a), .i_s_data(i_s_data),
      .o_m_valid(m_valid_a), .i_m_ready(i_m_ready), .o_m_data(m_data_a),
      .o_m_bin(m_bin_a), .o_m_last(m_last_a), .o_m_peak(m_peak_a), .o_m_sat(m_sat_a),
      .o_frame_done(fdone_a), .o_max_bin(max_bin_a), .o_max_val(max_val_a)
   );

   histogram_derivative_stream #(.NUM_BINS(NB), .IN_WIDTH(IW), .OUT_WIDTH(OWB)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(i_mode),
      .i_s_valid(i_s_valid), .o_s_ready(s_ready_b), .i_s_data(i_s_data),
      .o_m_valid(m_valid_b), .i_m_ready(i_m_ready), .o_m_data(m_data_b),
      .o_m_bin(m_bin_b), .o_m_last(m_last_b), .o_m_peak(m_peak_b), .o_m_sat(m_sat_b),
      .o_frame_done(fdone_b), .o_max_bin(max_bin_b), .o_max_val(max_val_b)
   );

   typedef struct {
      logic [15:0] h;
      int          d;
      bit          peak;
      bit          sat;
   } vec_t;

   typedef struct {
      int data;
      int bin;
      bit last;
      bit peak;
      bit sat;
      int cyc;
   } beat_t;

   vec_t        tbl [3][NB];   // 0: backward ramp, 1: central ramp, 2: saturation (8-bit)
   beat_t       got_a[$];
   beat_t       got_b[$];
   int          exp_ids[$];
   logic [15:0] stim_h [NB];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          fd_a    = 0;
   int          fd_b    = 0;
   int          nready  = 0;
   bit          rand_en = 1'b0;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_obs();
      got_a.delete();
      got_b.delete();
      exp_ids.delete();
      fd_a   = 0;
      fd_b   = 0;
      nready = 0;
   endtask

   task automatic load_stim(input int t);
      for (int k = 0; k < NB; k++) stim_h[k] = tbl[t][k].h;
   endtask

   // Drives nb bins from stim_h; mode m0 on bin 0, m1 on the rest.
   task automatic send_frame(input bit m0, input bit m1, input int nb);
      for (int k = 0; k < nb; k++) begin
         int  waitc;
         bit  done;
         waitc     = 0;
         done      = 1'b0;
         i_s_valid = 1'b1;
         i_s_data  = stim_h[k];
         i_mode    = (k == 0) ? m0 : m1;
         while (!done) begin
            @(negedge clk);
            done = s_ready_a;
            @(posedge clk);
            #1;
            waitc++;
            if (!done && waitc > 200) begin
               check("send_timeout", 0, 1);
               done = 1'b1;
            end
         end
      end
      i_s_valid = 1'b0;
   endtask

   task automatic compare_q(input string tag, input bit sel_b);
      int    n;
      beat_t b;
      vec_t  v;
      n = sel_b ? got_b.size() : got_a.size();
      check($sformatf("%s_count", tag), n, NB * exp_ids.size());
      for (int f = 0; f < exp_ids.size(); f++) begin
         for (int k = 0; k < NB; k++) begin
            int idx;
            idx = f * NB + k;
            if (idx < n) begin
               b = sel_b ? got_b[idx] : got_a[idx];
               v = tbl[exp_ids[f]][k];
               check($sformatf("%s_data%0d", tag, idx), b.data, v.d);
               check($sformatf("%s_bin%0d",  tag, idx), b.bin,  k);
               check($sformatf("%s_last%0d", tag, idx), b.last, (k == NB - 1));
               check($sformatf("%s_peak%0d", tag, idx), b.peak, v.peak);
               check($sformatf("%s_sat%0d",  tag, idx), b.sat,  v.sat);
            end
         end
      end
   endtask

   // Downstream ready: always 1, or a 50% coin flip when rand_en is set.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         i_m_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor on the falling edge: records handshakes, counts frame_done and
   // ready-low cycles, and checks that stalled outputs hold.
   initial begin
      bit          stall_a, stall_b;
      logic [63:0] held_a, held_b;
      stall_a = 1'b0;
      stall_b = 1'b0;
      held_a  = '0;
      held_b  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            stall_a = 1'b0;
            stall_b = 1'b0;
         end else begin
            if (stall_a)
               check("stable_a", {m_valid_a, m_data_a, m_bin_a, m_last_a, m_peak_a, m_sat_a}, held_a);
            if (stall_b)
               check("stable_b", {m_valid_b, m_data_b, m_bin_b, m_last_b, m_peak_b, m_sat_b}, held_b);
            stall_a = m_valid_a && !i_m_ready;
            stall_b = m_valid_b && !i_m_ready;
            held_a  = 64'({m_valid_a, m_data_a, m_bin_a, m_last_a, m_peak_a, m_sat_a});
            held_b  = 64'({m_valid_b, m_data_b, m_bin_b, m_last_b, m_peak_b, m_sat_b});
            if (m_valid_a && i_m_ready)
               got_a.push_back('{data: int'($signed(m_data_a)), bin: int'(m_bin_a),
                                 last: m_last_a, peak: m_peak_a, sat: m_sat_a, cyc: cyc});
            if (m_valid_b && i_m_ready)
               got_b.push_back('{data: int'($signed(m_data_b)), bin: int'(m_bin_b),
                                 last: m_last_b, peak: m_peak_b, sat: m_sat_b, cyc: cyc});
            if (fdone_a) fd_a++;
            if (fdone_b) fd_b++;
            if (!s_ready_a) nready++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sh [NB];
      int sd [NB];
      sh = '{0, 300, 300, 0, 0, 0, 0, 0};
      sd = '{0, 127, 0, -128, 0, 0, 0, 0};
      for (int k = 0; k < NB; k++) begin
         tbl[0][k] = '{h: 16'(k),     d: (k == 0) ? 0 : 1,          peak: 1'b0, sat: 1'b0};
         tbl[1][k] = '{h: 16'(2 * k), d: (k == 0 || k == 7) ? 1 : 2, peak: 1'b0, sat: 1'b0};
         tbl[2][k] = '{h: 16'(sh[k]), d: sd[k], peak: (k == 2), sat: (k == 1 || k == 3)};
      end

      // ---- reset / idle: reset held with valid asserted
      rst_n     = 1'b0;
      i_s_valid = 1'b1;
      i_s_data  = 16'h0055;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready",  s_ready_a, 0);
      check("rst_m_valid",  m_valid_a, 0);
      check("rst_m_data",   m_data_a,  0);
      check("rst_m_bin",    m_bin_a,   0);
      check("rst_flags",    {m_last_a, m_peak_a, m_sat_a}, 0);
      check("rst_fdone",    fdone_a,   0);
      check("rst_max",      {max_bin_a, max_val_a}, 0);
      check("rst_b_valid",  {m_valid_b, s_ready_b}, 0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      i_s_valid = 1'b0;
      @(negedge clk);
      check("rel_s_ready",  s_ready_a, 1);
      check("rel_m_valid",  m_valid_a, 0);
      @(posedge clk);
      #1;

      // ---- backward ramp
      clear_obs();
      load_stim(0);
      send_frame(1'b0, 1'b0, NB);
      idle(10);
      exp_ids.push_back(0);
      compare_q("bwd_a", 1'b0);
      compare_q("bwd_b", 1'b1);
      if (got_a.size() >= NB) check("bwd_span", got_a[NB-1].cyc - got_a[0].cyc, NB - 1);
      else                    check("bwd_span_beats", got_a.size(), NB);
      check("bwd_fdone", fd_a, 1);
      check("bwd_max_bin", max_bin_a, 1);
      check("bwd_max_val", $signed(max_val_a), 1);

      // ---- central ramp, i_mode dropped after bin 0 (must stay central)
      clear_obs();
      load_stim(1);
      send_frame(1'b1, 1'b0, NB);
      idle(10);
      exp_ids.push_back(1);
      compare_q("cen_a", 1'b0);
      compare_q("cen_b", 1'b1);
      if (got_a.size() >= NB) check("cen_span", got_a[NB-1].cyc - got_a[0].cyc, NB - 1);
      else                    check("cen_span_beats", got_a.size(), NB);
      check("cen_bubble", nready, 1);
      check("cen_fdone", fd_a, 1);
      check("cen_max_bin", max_bin_a, 1);
      check("cen_max_val", $signed(max_val_a), 2);

      // ---- saturation and peak on the 8-bit instance
      clear_obs();
      load_stim(2);
      send_frame(1'b0, 1'b0, NB);
      idle(10);
      exp_ids.push_back(2);
      compare_q("sat_b", 1'b1);
      check("sat_fdone_b", fd_b, 1);
      check("sat_max_bin_b", max_bin_b, 1);
      check("sat_max_val_b", $signed(max_val_b), 127);
      check("sat_max_val_a", $signed(max_val_a), 300);
      if (got_a.size() >= 4) begin
         check("sat_a_d1", got_a[1].data, 300);
         check("sat_a_peak2", got_a[2].peak, 1);
         check("sat_a_d3", got_a[3].data, -300);
      end else begin
         check("sat_a_beats", got_a.size(), NB);
      end

      // ---- backpressure: three frames with random downstream ready
      clear_obs();
      rand_en = 1'b1;
      load_stim(0);
      send_frame(1'b0, 1'b0, NB);
      load_stim(1);
      send_frame(1'b1, 1'b1, NB);
      load_stim(0);
      send_frame(1'b0, 1'b0, NB);
      idle(60);
      rand_en = 1'b0;
      idle(2);
      exp_ids.push_back(0);
      exp_ids.push_back(1);
      exp_ids.push_back(0);
      compare_q("bp_a", 1'b0);
      compare_q("bp_b", 1'b1);
      check("bp_fdone", fd_a, 3);
      check("bp_max_bin", max_bin_a, 1);
      check("bp_max_val", $signed(max_val_a), 1);

      // ---- reset mid-frame (backward, 5 bins), then a full central frame
      clear_obs();
      load_stim(0);
      send_frame(1'b0, 1'b0, 5);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("mid_rst_valid", m_valid_a, 0);
      check("mid_rst_max",   {max_bin_a, max_val_a}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      got_a.delete();
      got_b.delete();
      load_stim(1);
      send_frame(1'b1, 1'b1, NB);
      idle(10);
      exp_ids.push_back(1);
      compare_q("mid_a", 1'b0);
      check("mid_fdone", fd_a, 1);
      check("mid_max_bin", max_bin_a, 1);
      check("mid_max_val", $signed(max_val_a), 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
